// File: rtl/round_pipe.sv
// Two-stage pipelined fixed-point rounder (RNE/RHA/FLOOR/RTZ) with valid/ready on both sides and a
// saturating overflow counter. Define ROUND_PIPE_SAT_EN to clamp overflowed results to max positive.
module round_pipe #(
  parameter int DW = 16,
  parameter int FW = 8,
  parameter int CW = 8
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_a,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-FW-1:0]   out_z,
  output logic               out_ovf,
  output logic [CW-1:0]      ovf_cnt,
  input  logic               ovf_clr
);

  localparam int IW = DW - FW;
  localparam logic [IW-1:0] IMAX    = {1'b0, {(IW-1){1'b1}}};
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_RNE   = 2'd0;
  localparam logic [1:0] MODE_RHA   = 2'd1;
  localparam logic [1:0] MODE_FLOOR = 2'd2;
  localparam logic [1:0] MODE_RTZ   = 2'd3;

  // Handshake: a transfer happens on a side in any cycle where both valid and ready are high;
  // a valid, once raised, holds its data stable until that transfer.

  logic          s1_valid;
  logic [IW-1:0] s1_int;
  logic          s1_inc;

  logic [IW-1:0] d_int;
  logic          d_s, d_h, d_t, d_inc;

  logic          s1_take;
  logic          s2_load;
  logic          out_xfer;

  logic [IW-1:0] s1_sum;
  logic          s1_ovf;
  logic [IW-1:0] s1_z;

  always_comb begin
    d_int = in_a[DW-1:FW];
    d_s   = in_a[DW-1];
    d_h   = in_a[FW-1];
    d_t   = |in_a[FW-2:0];
    d_inc = 1'b0;
    case (in_mode)
      MODE_RNE:   d_inc = d_h & (d_t | d_int[0]);
      MODE_RHA:   d_inc = d_h & (d_t | ~d_s);
      MODE_FLOOR: d_inc = 1'b0;
      MODE_RTZ:   d_inc = d_s & (d_h | d_t);
      default:    d_inc = 1'b0;
    endcase
  end

  assign in_ready = ~s1_valid | ~out_valid | out_ready;
  assign s1_take  = in_valid & in_ready;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign out_xfer = out_valid & out_ready;

  // Adding one can only overflow from the largest positive integer.
  always_comb begin
    s1_sum = s1_int + {{(IW-1){1'b0}}, s1_inc};
    s1_ovf = s1_inc & (s1_int == IMAX);
`ifdef ROUND_PIPE_SAT_EN
    s1_z   = s1_ovf ? IMAX : s1_sum;
`else
    s1_z   = s1_sum;
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid <= 1'b0;
      s1_int   <= '0;
      s1_inc   <= 1'b0;
    end else begin
      if (s1_take) begin
        s1_valid <= 1'b1;
        s1_int   <= d_int;
        s1_inc   <= d_inc;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_z     <= s1_z;
        out_ovf   <= s1_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a coincident counted overflow.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_xfer && out_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule
